// File: rtl/ddr2_data_read_0_pkg.sv
// ddr2_data_read_0_pkg: shared parameters and types for the DDR2 read-data return path
package ddr2_data_read_0_pkg;
    localparam int DQ_WIDTH_DEF      = 16;
    localparam int BURST_LEN_DEF     = 4;
    localparam int RD_FIFO_DEPTH_DEF = 16;
    localparam int LAT_LINE          = 16;
    typedef enum logic {IDLE, BURST} rd_state_e;
    // A programmed latency of 0 behaves as 1
    function automatic logic [3:0] lat_tap(input logic [3:0] lat);
        return (lat == 4'd0) ? 4'd0 : lat - 4'd1;
    endfunction
endpackage

// File: rtl/ddr2_rd_fifo_0.sv
// ddr2_rd_fifo_0: first-word-fall-through read FIFO with registered valid/full flags
module ddr2_rd_fifo_0 #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 16
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout,
    output logic             valid,
    output logic             full
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0] wr_ptr, rd_ptr;
    logic [CW-1:0] count, count_next;
    logic do_push, do_pop;
    // A pop frees the slot the push needs, so full+pop still accepts the write
    always_comb begin
        do_pop = pop & valid;
        do_push = push & (~full | do_pop);
        count_next = count + CW'(do_push) - CW'(do_pop);
        dout = valid ? mem[rd_ptr] : '0;
    end
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count <= '0;
            valid <= 1'b0;
            full <= 1'b0;
        end else begin
            wr_ptr <= wr_ptr + AW'(do_push);
            rd_ptr <= rd_ptr + AW'(do_pop);
            count <= count_next;
            valid <= count_next != '0;
            full <= count_next == CW'(DEPTH);
        end
    end
    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= din;
    end
endmodule

// File: rtl/ddr2_data_read_0.sv
// ddr2_data_read_0: latency-timed capture of read bursts into a user-side FWFT FIFO
module ddr2_data_read_0
    import ddr2_data_read_0_pkg::*;
#(
    parameter int DQ_WIDTH   = DQ_WIDTH_DEF,
    parameter int BURST_LEN  = BURST_LEN_DEF,
    parameter int FIFO_DEPTH = RD_FIFO_DEPTH_DEF
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic [3:0]            rd_lat,
    input  logic                  ctrl_rden,
    input  logic [DQ_WIDTH-1:0]   rd_data_rise,
    input  logic [DQ_WIDTH-1:0]   rd_data_fall,
    input  logic                  user_rd_en,
    input  logic                  clr_err,
    output logic [2*DQ_WIDTH-1:0] user_rd_data,
    output logic                  user_rd_valid,
    output logic                  fifo_full,
    output logic                  burst_done,
    output logic                  overflow,
    output logic                  rd_err
);
    localparam int BEATS = BURST_LEN / 2;
    localparam int RW = $clog2(2 * BEATS + 1);
    logic [LAT_LINE-1:0] lat_line;
    logic [RW-1:0] remaining, remaining_next;
    rd_state_e state;
    logic rd_start, beat_vld, beat_q, push_drop;
    logic [2*DQ_WIDTH-1:0] word_q;
    // Starting in IDLE counts the current beat immediately; otherwise the whole burst is appended
    always_comb begin
        rd_start = lat_line[lat_tap(rd_lat)];
        state = (remaining != '0) ? BURST : IDLE;
        beat_vld = rd_start | (state == BURST);
        remaining_next = remaining - RW'(state == BURST)
                       + (rd_start ? RW'(state == IDLE ? BEATS - 1 : BEATS) : RW'(0));
        push_drop = beat_q & fifo_full & ~user_rd_en;
    end
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            lat_line <= '0;
            remaining <= '0;
            beat_q <= 1'b0;
            word_q <= '0;
            burst_done <= 1'b0;
            overflow <= 1'b0;
            rd_err <= 1'b0;
        end else begin
            lat_line <= {lat_line[LAT_LINE-2:0], ctrl_rden};
            remaining <= remaining_next;
            beat_q <= beat_vld;
            word_q <= {rd_data_rise, rd_data_fall};
            burst_done <= remaining == RW'(1);
            overflow <= push_drop | (overflow & ~clr_err);
            rd_err <= (rd_start & (remaining > RW'(1))) | (rd_err & ~clr_err);
        end
    end
    ddr2_rd_fifo_0 #(
        .WIDTH(2 * DQ_WIDTH),
        .DEPTH(FIFO_DEPTH)
    ) u_fifo (
        .clk(clk),
        .reset_n(reset_n),
        .push(beat_q),
        .pop(user_rd_en),
        .din(word_q),
        .dout(user_rd_data),
        .valid(user_rd_valid),
        .full(fifo_full)
    );
endmodule

// File: tb/tb_ddr2_data_read_0.sv
// tb_ddr2_data_read_0: directed and randomized check of the read return path against a queue model
module tb_ddr2_data_read_0;
    localparam int BEATS = 4;
    localparam int DEPTH = 16;
    logic clk = 1'b0;
    logic reset_n;
    logic [3:0] rd_lat;
    logic ctrl_rden, user_rd_en, clr_err;
    logic [15:0] rise, fall;
    logic [31:0] user_rd_data;
    logic user_rd_valid, fifo_full, burst_done, overflow, rd_err;
    int tests = 0;
    int fails = 0;
    bit run_cmp = 0;
    int done_cnt = 0;

    ddr2_data_read_0 #(
        .DQ_WIDTH(16),
        .BURST_LEN(8),
        .FIFO_DEPTH(DEPTH)
    ) dut (
        .clk(clk),
        .reset_n(reset_n),
        .rd_lat(rd_lat),
        .ctrl_rden(ctrl_rden),
        .rd_data_rise(rise),
        .rd_data_fall(fall),
        .user_rd_en(user_rd_en),
        .clr_err(clr_err),
        .user_rd_data(user_rd_data),
        .user_rd_valid(user_rd_valid),
        .fifo_full(fifo_full),
        .burst_done(burst_done),
        .overflow(overflow),
        .rd_err(rd_err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick;
        @(negedge clk);
    endtask

    // Model: each read command schedules a start cycle; each start owes BEATS beats,
    // one beat is taken per cycle, and a taken beat reaches the queue one edge later.
    int cyc;
    int starts[$];
    logic [31:0] q[$];
    int owed;
    bit stg_v, m_done, m_ovf, m_err;
    logic [31:0] stg_w;
    always @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cyc = 0;
            starts.delete();
            q.delete();
            owed = 0;
            stg_v = 0;
            stg_w = '0;
            m_done = 0;
            m_ovf = 0;
            m_err = 0;
        end else begin
            bit rs, pop, drop, err_set;
            int prior;
            rs = starts.size() > 0 && starts[0] == cyc;
            if (rs) void'(starts.pop_front());
            if (ctrl_rden) starts.push_back(cyc + ((rd_lat == 4'd0) ? 1 : int'(rd_lat)));
            pop = user_rd_en && q.size() > 0;
            drop = stg_v && q.size() == DEPTH && !pop;
            if (pop) void'(q.pop_front());
            if (stg_v && !drop) q.push_back(stg_w);
            err_set = rs && owed > 1;
            prior = owed;
            if (rs) owed += BEATS;
            stg_v = owed > 0;
            stg_w = {rise, fall};
            if (owed > 0) owed--;
            m_done = prior == 1;
            m_ovf = drop || (m_ovf && !clr_err);
            m_err = err_set || (m_err && !clr_err);
            cyc++;
        end
    end

    always @(negedge clk) begin
        if (reset_n && run_cmp) begin
            chk("valid", user_rd_valid, q.size() > 0);
            chk("full", fifo_full, q.size() == DEPTH);
            if (q.size() > 0) chk("data", user_rd_data, q[0]);
            chk("burst_done", burst_done, m_done);
            chk("overflow", overflow, m_ovf);
            chk("rd_err", rd_err, m_err);
        end
        if (reset_n && burst_done) done_cnt++;
    end

    task automatic drain(input string name, input int exp_n, input bit seq, input logic [15:0] first);
        int n = 0;
        while (user_rd_valid && n < 40) begin
            if (seq) chk(name, user_rd_data[31:16], first + 16'(n));
            user_rd_en = 1'b1;
            tick;
            n++;
        end
        user_rd_en = 1'b0;
        chk({name, "_count"}, n, exp_n);
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, "_valid"}, user_rd_valid, 0);
        chk({tag, "_data"}, user_rd_data, 0);
        chk({tag, "_full"}, fifo_full, 0);
        chk({tag, "_done"}, burst_done, 0);
        chk({tag, "_ovf"}, overflow, 0);
        chk({tag, "_err"}, rd_err, 0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        int base, need, gap, pop_pct;
        reset_n = 1'b0;
        ctrl_rden = 1'b0;
        user_rd_en = 1'b0;
        clr_err = 1'b0;
        rd_lat = 4'd5;
        rise = '0;
        fall = '0;
        #3;
        chk_zero("reset");
        tick;
        tick;
        reset_n = 1'b1;
        run_cmp = 1;
        tick;

        // Single burst, latency 5
        ctrl_rden = 1'b1;
        tick;
        ctrl_rden = 1'b0;
        repeat (4) tick;
        rise = 16'h1111; fall = 16'h2222; tick;
        chk("sb_not_yet", user_rd_valid, 0);
        rise = 16'h3333; fall = 16'h4444; tick;
        chk("sb_valid", user_rd_valid, 1);
        chk("sb_head", user_rd_data, 32'h11112222);
        rise = 16'h5555; fall = 16'h6666; user_rd_en = 1'b1; tick;
        user_rd_en = 1'b0;
        chk("sb_pop_head", user_rd_data, 32'h33334444);
        rise = 16'h7777; fall = 16'h8888; tick;
        chk("sb_done", burst_done, 1);
        rise = 16'h9999; tick;
        chk("sb_done_low", burst_done, 0);
        drain("sb_rest", 3, 0, 16'h0);

        // Back-to-back bursts, latency 3, commands at T and T+4
        rd_lat = 4'd3;
        base = done_cnt;
        ctrl_rden = 1'b1; rise = 16'd0; fall = ~rise; tick;
        for (int i = 1; i <= 14; i++) begin
            ctrl_rden = (i == 4); rise = 16'(i); fall = ~rise; tick;
        end
        chk("b2b_err", rd_err, 0);
        chk("b2b_done_cnt", done_cnt - base, 2);
        drain("b2b_seq", 8, 1, 16'd3);

        // Overlapping bursts, commands at T and T+2
        ctrl_rden = 1'b1; rise = 16'd0; fall = ~rise; tick;
        for (int i = 1; i <= 12; i++) begin
            ctrl_rden = (i == 2); rise = 16'(i); fall = ~rise; tick;
        end
        chk("ovl_err", rd_err, 1);
        clr_err = 1'b1; tick;
        clr_err = 1'b0;
        chk("ovl_err_clr", rd_err, 0);
        drain("ovl_seq", 8, 1, 16'd3);

        // Overflow: five bursts without pops
        ctrl_rden = 1'b1; rise = 16'd0; fall = ~rise; tick;
        for (int i = 1; i <= 26; i++) begin
            ctrl_rden = (i % 4 == 0) && (i <= 16); rise = 16'(i); fall = ~rise; tick;
        end
        chk("ovf_full", fifo_full, 1);
        chk("ovf_flag", overflow, 1);
        chk("ovf_head", user_rd_data[31:16], 16'd3);
        clr_err = 1'b1; tick;
        clr_err = 1'b0;
        chk("ovf_clr", overflow, 0);

        // Full FIFO with push and pop in the same cycles
        ctrl_rden = 1'b1; rise = 16'h8000; fall = ~rise; tick;
        for (int i = 1; i <= 10; i++) begin
            ctrl_rden = 1'b0; user_rd_en = (i >= 4 && i <= 7);
            rise = 16'h8000 + 16'(i); fall = ~rise; tick;
        end
        user_rd_en = 1'b0;
        chk("simul_full", fifo_full, 1);
        chk("simul_no_ovf", overflow, 0);
        chk("simul_head", user_rd_data[31:16], 16'd7);
        drain("simul_drain", 16, 0, 16'h0);

        // Reset while beat 2 of a burst is on the bus
        ctrl_rden = 1'b1; tick;
        ctrl_rden = 1'b0;
        for (int i = 1; i <= 4; i++) begin
            rise = 16'hA000 + 16'(i); fall = ~rise; tick;
        end
        chk("rst_pre_valid", user_rd_valid, 1);
        #2 reset_n = 1'b0;
        #1 chk_zero("rst_async");
        tick;
        tick;
        reset_n = 1'b1;
        repeat (12) tick;
        chk("rst_no_push", user_rd_valid, 0);

        // Randomized traffic, latency changed only while idle
        for (int seg = 0; seg < 12; seg++) begin
            rd_lat = 4'($urandom_range(0, 7));
            pop_pct = $urandom_range(0, 100);
            need = $urandom_range(2, 8);
            gap = 9;
            for (int c = 0; c < 150; c++) begin
                rise = 16'($urandom); fall = 16'($urandom);
                clr_err = ($urandom_range(0, 15) == 0);
                user_rd_en = ($urandom_range(0, 99) < pop_pct);
                ctrl_rden = 1'b0;
                gap++;
                if (c < 125 && gap >= need) begin
                    ctrl_rden = 1'b1;
                    need = (gap == 2) ? $urandom_range(5, 8) : $urandom_range(2, 8);
                    gap = 0;
                end
                tick;
            end
        end
        clr_err = 1'b0;
        ctrl_rden = 1'b0;
        drain("final_drain", q.size(), 0, 16'h0);
        tick;
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
